// File: rtl/puf_response_gen.sv
// rtl/puf_response_gen.sv - ring-oscillator PUF evaluation core producing a RESP_W-bit response
//
// Purpose:
//   Each challenge runs RESP_W races between two ring oscillators. For bit i the
//   pair is a = (challenge + i) mod N_RO and b = a + N_RO/2. Each race has a
//   SETTLE phase, a WIN_CYCLES counting window and a one-cycle compare. The
//   result bits shift into the response word, so the first bit ends up in the MSB.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   challenge    challenge byte, latched only when start is accepted in IDLE
//   start        single-cycle request pulse
//   ro_out       raw RO outputs, asynchronous to clk
//   ro_en        enables for the selected RO pair during SETTLE/COUNT
//   response     evaluated response word, held until it is overwritten
//   response_DV  single-cycle pulse in the DONE state
//   busy         high in every state except IDLE
//   sat_err      (PUF_SAT_FLAG_EN only) sticky flag: a counter reached saturation
//
// Optional feature macro: PUF_SAT_FLAG_EN adds the sat_err output.

module puf_response_gen #(
    parameter int N_RO          = 16,
    parameter int RESP_W        = 256,
    parameter int WIN_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        challenge,
    input  logic              start,
    input  logic [N_RO-1:0]   ro_out,
    output logic [N_RO-1:0]   ro_en,
    output logic [RESP_W-1:0] response,
    output logic              response_DV,
`ifdef PUF_SAT_FLAG_EN
    output logic              sat_err,
`endif
    output logic              busy
);

    localparam int L       = $clog2(N_RO);
    localparam int IDX_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q;
    logic [7:0]         chal_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_a, cnt_b;
    // Each vector holds {edge register, sync stage 2, sync stage 1}.
    logic [2:0]         sync_a, sync_b;
    logic [L-1:0]       sel_a, sel_b;
    logic               rise_a, rise_b;
    logic               last_bit;

    // The 8-bit sum is truncated to L bits. Because N_RO is a power of two, this
    // gives (challenge + i) mod N_RO. Adding N_RO/2 only flips the top select bit.
    assign sel_a    = L'(chal_q + 8'(idx_q));
    assign sel_b    = {~sel_a[L-1], sel_a[L-2:0]};
    assign rise_a   = sync_a[1] & ~sync_a[2];
    assign rise_b   = sync_b[1] & ~sync_b[2];
    assign last_bit = (idx_q == IDX_W'(RESP_W - 1));

    always_comb begin
        state_d     = state_q;
        ro_en       = '0;
        busy        = (state_q != S_IDLE);
        response_DV = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                ro_en[sel_a] = 1'b1;
                ro_en[sel_b] = 1'b1;
                if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) state_d = S_COUNT;
            end
            S_COUNT: begin
                ro_en[sel_a] = 1'b1;
                ro_en[sel_b] = 1'b1;
                if (tmr_q == TMR_W'(WIN_CYCLES - 1)) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                state_d = last_bit ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            chal_q   <= '0;
            idx_q    <= '0;
            sync_a   <= '0;
            sync_b   <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            response <= '0;
        end else begin
            state_q <= state_d;
            // The phase timer restarts on every state change. It stays at zero while idle.
            tmr_q   <= (state_d != state_q || state_q == S_IDLE) ? '0 : tmr_q + 1'b1;
            // The selected RO is muxed ahead of the synchroniser. SETTLE lasts long
            // enough to flush the previous pair out of all three stages.
            sync_a  <= {sync_a[1:0], ro_out[sel_a]};
            sync_b  <= {sync_b[1:0], ro_out[sel_b]};
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        chal_q <= challenge;
                        idx_q  <= '0;
                    end
                end
                S_SETTLE: begin
                    cnt_a <= '0;
                    cnt_b <= '0;
                end
                S_COUNT: begin
                    if (rise_a && cnt_a != CNT_MAX) cnt_a <= cnt_a + 1'b1;
                    if (rise_b && cnt_b != CNT_MAX) cnt_b <= cnt_b + 1'b1;
                end
                S_COMPARE: begin
                    response <= {response[RESP_W-2:0], (cnt_a > cnt_b)};
                    if (!last_bit) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PUF_SAT_FLAG_EN
    // Set on the edge that drives a counter to its maximum. It is also set while a
    // counter already sits there, so saturation on the last window cycle is not missed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_err <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            sat_err <= 1'b0;
        end else if (state_q == S_COUNT &&
                     ((rise_a && cnt_a >= CNT_MAX - 1'b1) ||
                      (rise_b && cnt_b >= CNT_MAX - 1'b1))) begin
            sat_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_puf_response_gen.sv
// tb/tb_puf_response_gen.sv - randomized self-checking bench for puf_response_gen

module tb_puf_response_gen;

    localparam int N_RO   = 4;
    localparam int RESP_W = 8;
    localparam int WIN    = 32;
    localparam int SETTLE = 4;
`ifdef PUF_SAT_FLAG_EN
    localparam int CNT_W  = 3;
`else
    localparam int CNT_W  = 8;
`endif
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int PER_BIT  = SETTLE + WIN + 1;
    localparam int DV_CYCLE = RESP_W * PER_BIT + 1;

    logic              clk;
    logic              reset;
    logic [7:0]        challenge;
    logic              start;
    logic [N_RO-1:0]   ro_out;
    logic [N_RO-1:0]   ro_en;
    logic [RESP_W-1:0] response;
    logic              response_DV;
    logic              busy;
`ifdef PUF_SAT_FLAG_EN
    logic              sat_err;
`endif

    int checks = 0;
    int errors = 0;

    puf_response_gen #(
        .N_RO(N_RO), .RESP_W(RESP_W), .WIN_CYCLES(WIN),
        .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .challenge(challenge),
        .start(start),
        .ro_out(ro_out),
        .ro_en(ro_en),
        .response(response),
        .response_DV(response_DV),
`ifdef PUF_SAT_FLAG_EN
        .sat_err(sat_err),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each RO is a square wave with a period given in clk cycles (0 means stuck low).
    // Every period divides WIN, so each window sees exactly WIN/period rising edges.
    int period [N_RO];
    int phase  [N_RO];
    int tick = 0;

    always @(negedge clk) begin
        tick = tick + 1;
        for (int j = 0; j < N_RO; j++)
            ro_out[j] = (period[j] == 0) ? 1'b0 :
                        (((tick + phase[j]) % period[j]) < (period[j] / 2));
    end

    function automatic int model_raw(input int j);
        return (period[j] == 0) ? 0 : WIN / period[j];
    endfunction

    function automatic int model_cnt(input int j);
        int r;
        r = model_raw(j);
        return (r > CNT_MAX) ? CNT_MAX : r;
    endfunction

    function automatic int pair_a(input logic [7:0] ch, input int i);
        return (int'(ch) + i) % N_RO;
    endfunction

    function automatic logic [RESP_W-1:0] model_resp(input logic [7:0] ch);
        logic [RESP_W-1:0] r;
        int a, b;
        r = '0;
        for (int i = 0; i < RESP_W; i++) begin
            a = pair_a(ch, i);
            b = (a + N_RO / 2) % N_RO;
            r = {r[RESP_W-2:0], model_cnt(a) > model_cnt(b)};
        end
        return r;
    endfunction

    function automatic logic model_sat(input logic [7:0] ch);
        logic s;
        int a, b;
        s = 1'b0;
        for (int i = 0; i < RESP_W; i++) begin
            a = pair_a(ch, i);
            b = (a + N_RO / 2) % N_RO;
            if (model_raw(a) >= CNT_MAX || model_raw(b) >= CNT_MAX) s = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [N_RO-1:0] model_en(input logic [7:0] ch, input int cyc);
        logic [N_RO-1:0] m;
        int k, a;
        m = '0;
        k = cyc - 1;
        if (cyc >= 1 && cyc < DV_CYCLE && (k % PER_BIT) < SETTLE + WIN) begin
            a = pair_a(ch, k / PER_BIT);
            m[a] = 1'b1;
            m[(a + N_RO / 2) % N_RO] = 1'b1;
        end
        return m;
    endfunction

    // Starts one evaluation and gathers what the DUT does. It makes no judgement;
    // the calling tests compare the collected values against the model.
    task automatic run_eval(input logic [7:0] ch, input int spur, input bit spur_dv,
                            output int dv_cycle, output int dv_count,
                            output logic [RESP_W-1:0] resp_dv,
                            output int en_bad, output int busy_bad, output logic sat_dv);
        @(negedge clk);
        challenge = ch;
        start = 1'b1;
        @(posedge clk);
        #1;
        dv_cycle = -1;
        dv_count = 0;
        resp_dv  = '0;
        en_bad   = 0;
        busy_bad = 0;
        sat_dv   = 1'b0;
        for (int cyc = 1; cyc <= DV_CYCLE + 30; cyc++) begin
            start = 1'b0;
            challenge = 8'($urandom);
            if (ro_en !== model_en(ch, cyc)) en_bad++;
            if (busy !== (cyc <= DV_CYCLE)) busy_bad++;
            if (response_DV === 1'b1) begin
                dv_count++;
                if (dv_cycle < 0) begin
                    dv_cycle = cyc;
                    resp_dv = response;
`ifdef PUF_SAT_FLAG_EN
                    sat_dv = sat_err;
`endif
                end
            end
            if (cyc == spur || (spur_dv && cyc == DV_CYCLE)) start = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic set_directed();
        period[0] = 4; period[1] = 8; period[2] = 4; period[3] = 16;
        for (int j = 0; j < N_RO; j++) phase[j] = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        challenge = '0;
        for (int j = 0; j < N_RO; j++) begin period[j] = 0; phase[j] = 0; end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (response !== '0) begin errors++; $display("FAIL reset_response got %h want 00", response); end
        checks++; if (ro_en !== '0) begin errors++; $display("FAIL reset_ro_en got %b want 0000", ro_en); end
        checks++; if (response_DV !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", response_DV); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_eval(input string name, input logic [7:0] ch);
        int dvc, dvn, eb, bb;
        logic [RESP_W-1:0] r, exp;
        logic s;
        exp = model_resp(ch);
        run_eval(ch, -1, 1'b0, dvc, dvn, r, eb, bb, s);
        checks++; if (r !== exp) begin errors++; $display("FAIL %s_response ch=%h got %h want %h", name, ch, r, exp); end
        checks++; if (dvc !== DV_CYCLE) begin errors++; $display("FAIL %s_dv_cycle got %0d want %0d", name, dvc, DV_CYCLE); end
        checks++; if (dvn !== 1) begin errors++; $display("FAIL %s_dv_count got %0d want 1", name, dvn); end
        checks++; if (eb !== 0) begin errors++; $display("FAIL %s_ro_en bad_cycles got %0d want 0", name, eb); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL %s_busy bad_cycles got %0d want 0", name, bb); end
`ifdef PUF_SAT_FLAG_EN
        checks++; if (s !== model_sat(ch)) begin errors++; $display("FAIL %s_sat_err got %b want %b", name, s, model_sat(ch)); end
`endif
    endtask

    task automatic test_ignore_start();
        int dvc, dvn, eb, bb;
        logic [RESP_W-1:0] r, exp;
        logic s;
        set_directed();
        exp = model_resp(8'h00);
        run_eval(8'h00, 10, 1'b1, dvc, dvn, r, eb, bb, s);
        checks++; if (r !== exp) begin errors++; $display("FAIL ignore_response got %h want %h", r, exp); end
        checks++; if (dvn !== 1) begin errors++; $display("FAIL ignore_dv_count got %0d want 1", dvn); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL ignore_busy bad_cycles got %0d want 0", bb); end
        checks++; if (response !== exp) begin errors++; $display("FAIL ignore_hold got %h want %h", response, exp); end
    endtask

    task automatic test_reset_mid();
        int dvn, bsy;
        set_directed();
        @(negedge clk);
        challenge = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Cycle 160 lies inside the counting window of the fifth bit.
        repeat (159) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_async got %b want 0", busy); end
        checks++; if (response !== '0) begin errors++; $display("FAIL rstmid_response got %h want 00", response); end
        checks++; if (ro_en !== '0) begin errors++; $display("FAIL rstmid_ro_en got %b want 0000", ro_en); end
        checks++; if (response_DV !== 1'b0) begin errors++; $display("FAIL rstmid_dv got %b want 0", response_DV); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_next got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        dvn = 0;
        bsy = 0;
        for (int c = 0; c < DV_CYCLE + 40; c++) begin
            @(posedge clk);
            #1;
            if (response_DV === 1'b1) dvn++;
            if (busy !== 1'b0) bsy++;
        end
        checks++; if (dvn !== 0) begin errors++; $display("FAIL rstmid_no_dv got %0d want 0", dvn); end
        checks++; if (bsy !== 0) begin errors++; $display("FAIL rstmid_idle got %0d busy cycles want 0", bsy); end
        test_eval("rstmid_fresh", 8'h00);
    endtask

    task automatic test_all_zero();
        for (int j = 0; j < N_RO; j++) period[j] = 0;
        test_eval("zero", 8'($urandom));
    endtask

    task automatic test_random();
        int choices [5] = '{0, 4, 8, 16, 32};
        for (int n = 0; n < 6; n++) begin
            for (int j = 0; j < N_RO; j++) begin
                period[j] = choices[$urandom_range(0, 4)];
                phase[j]  = int'($urandom_range(0, 31));
            end
            test_eval("random", 8'($urandom));
        end
    endtask

`ifdef PUF_SAT_FLAG_EN
    task automatic test_sat_clear();
        set_directed();
        test_eval("sat", 8'h00);
        for (int j = 0; j < N_RO; j++) period[j] = 0;
        @(negedge clk);
        challenge = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (sat_err !== 1'b0) begin errors++; $display("FAIL sat_clear got %b want 0", sat_err); end
        repeat (DV_CYCLE + 5) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        set_directed();
        test_eval("ch00", 8'h00);
        test_eval("ch01", 8'h01);
        test_ignore_start();
        test_reset_mid();
        test_all_zero();
        test_random();
`ifdef PUF_SAT_FLAG_EN
        test_sat_clear();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
